// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit: fetch FSM states, PCSrc encodings,
// default vectors and small PC arithmetic helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_REG    = 3'b011;
  localparam logic [2:0] PCSRC_IRQ    = 3'b100;
  localparam logic [2:0] PCSRC_EXC    = 3'b101;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

  // Bit 31 is the kernel/user flag and never changes by sequential fetch.
  function automatic logic [31:0] calc_pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection driven by the decoder's PCSrc code.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic [2:0]  pc_src,
  input  logic        alu_out0,
  input  logic [31:0] pc,
  input  logic [25:0] instr_field,
  input  logic [31:0] databus_a,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  always_comb begin
    pc_plus4 = calc_pc_plus4(pc);
    next_pc  = pc_plus4;
    case (pc_src)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = alu_out0 ? (pc_plus4 + branch_offset(instr_field[15:0]))
                                       : pc_plus4;
      PCSRC_JUMP:   next_pc = {pc[31:28], instr_field, 2'b00};
      // A register jump may leave kernel mode but can never enter it.
      PCSRC_REG:    next_pc = {pc[31] & databus_a[31], databus_a[30:0]};
      PCSRC_IRQ:    next_pc = ILLOP_VEC;
      PCSRC_EXC:    next_pc = XADR_VEC;
      default:      next_pc = XADR_VEC;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/FETCH/EXEC FSM, PC register, interrupt
// pending logic. Define FETCH_IMEM_HANDSHAKE_EN to make FETCH wait on imem_ready.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, nothing requested yet
// ST_FETCH | imem_req high, PC presented as address, waiting for the word
// ST_EXEC  | exec strobe, PC and pending interrupt update on this edge
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        ALUOut0,
  input  logic [31:0] DatabusA,
  input  logic        irq_in,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        IRQ,
  output logic        exec,
  output logic [31:0] LinkAddr
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         pending;
  logic         word_ok;
  logic         fetch_done;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;

`ifdef FETCH_IMEM_HANDSHAKE_EN
  assign word_ok = imem_ready;
`else
  // Without the handshake every FETCH completes in one cycle; imem_ready
  // is referenced only so the port is not reported as dangling.
  assign word_ok = 1'b1 | imem_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    exec       = 1'b0;
    fetch_done = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req   = 1'b1;
        fetch_done = word_ok;
        if (word_ok) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec       = 1'b1;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Interrupts are only taken in user mode; kernel code keeps them pending.
  assign IRQ      = pending & ~PC[31] & exec;
  assign LinkAddr = IRQ ? PC : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC          <= RESET_VEC;
      Instruction <= 32'h0;
      pending     <= 1'b0;
    end else begin
      if (fetch_done) begin
        Instruction <= imem_rdata;
      end
      if (exec) begin
        PC <= next_pc;
      end
      // A new request arriving on the taking edge stays pending.
      if (irq_in) begin
        pending <= 1'b1;
      end else if (IRQ) begin
        pending <= 1'b0;
      end
    end
  end

  pc_next_mux #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_pc_next_mux (
    .pc_src      (PCSrc),
    .alu_out0    (ALUOut0),
    .pc          (PC),
    .instr_field (Instruction[25:0]),
    .databus_a   (DatabusA),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter ILLOP_VEC, default 32'h8000_0004, interrupt entry.
REQ-003 SHALL have parameter XADR_VEC, default 32'h8000_0008, undefined-instruction entry.
REQ-004 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have PCSrc, input, 3, next-PC select from the decoder: 000 seq, 001 branch, 010 jump, 011 register, 100 interrupt, 101 exception.
REQ-007 SHALL have ALUOut0, input, 1, branch condition (1 = taken).
REQ-008 SHALL have DatabusA, input, 32, rs value for jr/jalr.
REQ-009 SHALL have irq_in, input, 1, external interrupt request (level).
REQ-010 SHALL have imem_rdata, input, 32, instruction word; imem_ready, input, 1, word valid.
REQ-011 SHALL have imem_req, output, 1, fetch request; PC, output, 32, current PC (also imem address).
REQ-012 SHALL have Instruction, output, 32, held instruction word; IRQ, output, 1, interrupt to decoder.
REQ-013 SHALL have exec, output, 1, commit strobe gating register-file and memory writes; LinkAddr, output, 32, value written by jal/jalr/interrupt/exception.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, EXEC; IDLE->FETCH next cycle; FETCH->EXEC on imem_ready; EXEC->FETCH always.
REQ-015 SHALL assert imem_req only in FETCH, holding PC stable until imem_ready.
REQ-016 SHALL capture imem_rdata into Instruction on the FETCH cycle with imem_ready=1; Instruction holds otherwise.
REQ-017 SHALL assert exec exactly one cycle per instruction (EXEC state); PC updates only on that edge.
REQ-018 SHALL compute PCPlus4 as {PC[31], PC[30:0]+4} (bit 31 preserved, bits 30:0 wrap).
REQ-019 SHALL select next PC: 000 PCPlus4; 001 ALUOut0 ? PCPlus4 + (sext(Instruction[15:0])<<2) : PCPlus4; 010 {PC[31:28], Instruction[25:0], 2'b00}; 011 DatabusA with bit 31 forced to PC[31] & DatabusA[31]; 100 ILLOP_VEC; 101 XADR_VEC; 110/111 XADR_VEC.
REQ-020 SHALL set a pending flag on irq_in=1 in any cycle; flag clears on the EXEC edge where IRQ=1.
REQ-021 SHALL drive IRQ = pending & ~PC[31] & (state==EXEC); irq_in asserted during EXEC is not seen until the next EXEC.
REQ-022 SHALL drive LinkAddr = PC when IRQ=1 (interrupted instruction re-executes), else PCPlus4.
REQ-023 SHALL keep pending set while PC[31]=1 (kernel) and raise IRQ at the first EXEC after return to user mode.

Reset
REQ-024 SHALL on reset set state IDLE, PC=RESET_VEC, Instruction=0, pending=0; imem_req, exec, IRQ = 0 in the following cycle.
REQ-025 SHALL let reset override any state, including mid-FETCH with imem_ready=1 (word discarded).

Configuration
REQ-026 SHALL support macro FETCH_IMEM_HANDSHAKE_EN: defined, FETCH waits for imem_ready; undefined, imem_ready ignored and FETCH lasts exactly one cycle.

Structure
REQ-027 SHALL take PCSrc encodings, vector defaults and the state enum from shared package cpu_pkg.
REQ-028 SHALL place next-PC selection in combinational sub-module pc_next_mux.

Verification
REQ-029 SHALL cover: reset, imem_ready=1 always -> PC 8000_0000, 8000_0004, 8000_0008 on successive EXECs; exec every 2nd cycle.
REQ-030 SHALL cover: PC=0000_0010, PCSrc=001, imm=16'hFFFE, ALUOut0=1 -> PC=0000_000C; ALUOut0=0 -> 0000_0014.
REQ-031 SHALL cover: PC=0000_0040, PCSrc=011, DatabusA=8000_0100 -> PC=0000_0100 (user cannot enter kernel).
REQ-032 SHALL cover: irq_in pulse while PC=0000_0020 -> IRQ=1 at next EXEC, LinkAddr=0000_0020, PCSrc=100 -> PC=8000_0004, pending=0.
REQ-033 SHALL cover: imem_ready low 3 cycles in FETCH -> PC and imem_req held, exec=0; with macro undefined, EXEC follows after 1 cycle.
REQ-034 SHALL cover: reset asserted in FETCH with imem_ready=1 -> Instruction=0, PC=8000_0000, state IDLE.
